// File: rtl/fir_pkg.sv
// Shared encodings and tap geometry for the FIR coefficient RAM arbiter.
package fir_pkg;

  typedef enum logic {
    ARB       = 1'b0,
    ENG_BURST = 1'b1
  } arb_state_e;

  typedef enum logic {
    CFG = 1'b0,
    ENG = 1'b1
  } owner_e;

  localparam int unsigned TAP_NUM    = 11;
  localparam int unsigned TAP_STRIDE = 4;

endpackage

// File: rtl/tap_ram_arbiter_if.sv
// Request/grant/return bundle between cfg path, FIR engine and the tap BRAM pins.
interface tap_ram_arbiter_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
);
  logic                   cfg_req;
  logic                   cfg_we;
  logic [pADDR_WIDTH-1:0] cfg_addr;
  logic [pDATA_WIDTH-1:0] cfg_wdata;
  logic                   cfg_gnt;
  logic                   cfg_rvalid;
  logic [pDATA_WIDTH-1:0] cfg_rdata;
  logic                   cfg_wr_blocked;

  logic                   eng_req;
  logic [pADDR_WIDTH-1:0] eng_addr;
  logic                   eng_gnt;
  logic                   eng_rvalid;
  logic [pDATA_WIDTH-1:0] eng_rdata;
  logic                   eng_lock;

  logic                   tap_EN;
  logic [3:0]             tap_WE;
  logic [pADDR_WIDTH-1:0] tap_A;
  logic [pDATA_WIDTH-1:0] tap_Di;
  logic [pDATA_WIDTH-1:0] tap_Do;

  modport slave (
    input  cfg_req, cfg_we, cfg_addr, cfg_wdata, eng_req, eng_addr, eng_lock, tap_Do,
    output cfg_gnt, cfg_rvalid, cfg_rdata, cfg_wr_blocked,
    output eng_gnt, eng_rvalid, eng_rdata,
    output tap_EN, tap_WE, tap_A, tap_Di
  );

  modport master (
    output cfg_req, cfg_we, cfg_addr, cfg_wdata, eng_req, eng_addr, eng_lock, tap_Do,
    input  cfg_gnt, cfg_rvalid, cfg_rdata, cfg_wr_blocked,
    input  eng_gnt, eng_rvalid, eng_rdata,
    input  tap_EN, tap_WE, tap_A, tap_Di
  );
endinterface

// File: rtl/tap_ram_arbiter.sv
// Single-port tap BRAM arbiter: engine read bursts vs. cfg read/write with
// write lockout while the engine runs and a bounded cfg wait.
module tap_ram_arbiter
  import fir_pkg::*;
#(
  parameter int unsigned BURST_LEN = TAP_NUM,
  parameter int unsigned MAX_WAIT  = 16
) (
  input  logic               axis_clk,
  input  logic               axis_rst,
  tap_ram_arbiter_if.slave   bus
);

  localparam int unsigned BCW = $clog2(BURST_LEN + 1);
  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

  arb_state_e     state_q, state_d;
  owner_e         rr_q, rr_d;
  owner_e         rd_own_q, rd_own_d;
  logic           rd_vld_q, rd_vld_d;
  logic [BCW-1:0] burst_q, burst_d;
  logic [WCW-1:0] wait_q, wait_d;

  logic cfg_elig_c, eng_req_c, starved_c;
  logic cfg_gnt_c, eng_gnt_c;
  logic cfg_rvalid_c, eng_rvalid_c;

  // Requests are masked while reset is asserted so every output drops at once.
  always_comb begin
    cfg_elig_c = ~axis_rst & bus.cfg_req & ~(bus.cfg_we & bus.eng_lock);
    eng_req_c  = ~axis_rst & bus.eng_req;
    starved_c  = (wait_q == WCW'(MAX_WAIT));
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    burst_d   = burst_q;
    cfg_gnt_c = 1'b0;
    eng_gnt_c = 1'b0;
    unique case (state_q)
      ARB: begin
        if (cfg_elig_c && (starved_c || !eng_req_c)) begin
          cfg_gnt_c = 1'b1;
        end else if (eng_req_c && (!cfg_elig_c || rr_q == CFG)) begin
          eng_gnt_c = 1'b1;
        end else if (cfg_elig_c) begin
          cfg_gnt_c = 1'b1;
        end
        if (eng_gnt_c) begin
          rr_d    = ENG;
          burst_d = BCW'(1);
          state_d = ENG_BURST;
        end else if (cfg_gnt_c) begin
          rr_d = CFG;
        end
      end
      ENG_BURST: begin
        if (eng_req_c && (burst_q < BCW'(BURST_LEN)) && !starved_c) begin
          eng_gnt_c = 1'b1;
          burst_d   = burst_q + BCW'(1);
        end else begin
          // Leaving the burst hands the same cycle to a waiting cfg request.
          cfg_gnt_c = cfg_elig_c;
          if (cfg_elig_c) rr_d = CFG;
          burst_d = '0;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (cfg_gnt_c) begin
      wait_d = '0;
    end else if (cfg_elig_c && !starved_c) begin
      wait_d = wait_q + WCW'(1);
    end
    rd_vld_d = eng_gnt_c | (cfg_gnt_c & ~bus.cfg_we);
    rd_own_d = eng_gnt_c ? ENG : CFG;
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q  <= ARB;
      rr_q     <= CFG;
      burst_q  <= '0;
      wait_q   <= '0;
      rd_vld_q <= 1'b0;
      rd_own_q <= CFG;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      burst_q  <= burst_d;
      wait_q   <= wait_d;
      rd_vld_q <= rd_vld_d;
      rd_own_q <= rd_own_d;
    end
  end

  assign cfg_rvalid_c = rd_vld_q & (rd_own_q == CFG);
  assign eng_rvalid_c = rd_vld_q & (rd_own_q == ENG);

  assign bus.cfg_gnt        = cfg_gnt_c;
  assign bus.eng_gnt        = eng_gnt_c;
  assign bus.cfg_wr_blocked = ~axis_rst & bus.cfg_req & bus.cfg_we & bus.eng_lock;
  assign bus.cfg_rvalid     = cfg_rvalid_c;
  assign bus.eng_rvalid     = eng_rvalid_c;
  assign bus.cfg_rdata      = cfg_rvalid_c ? bus.tap_Do : '0;
  assign bus.eng_rdata      = eng_rvalid_c ? bus.tap_Do : '0;

  assign bus.tap_EN = cfg_gnt_c | eng_gnt_c;
  assign bus.tap_WE = {4{cfg_gnt_c & bus.cfg_we}};
  assign bus.tap_A  = cfg_gnt_c ? bus.cfg_addr : (eng_gnt_c ? bus.eng_addr : '0);
  assign bus.tap_Di = cfg_gnt_c ? bus.cfg_wdata : '0;

endmodule

// File: tb/tb_tap_ram_arbiter.sv
// Bench for tap_ram_arbiter: vector table, directed burst/starvation/reset
// sequences, and randomized traffic against a behavioural arbitration model.
module tb_tap_ram_arbiter;
  import fir_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tap_ram_arbiter_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) b0 ();
  tap_ram_arbiter_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) b1 ();

  tap_ram_arbiter #(.BURST_LEN(TAP_NUM), .MAX_WAIT(16)) dut0 (
    .axis_clk(clk), .axis_rst(rst), .bus(b0)
  );
  tap_ram_arbiter #(.BURST_LEN(32), .MAX_WAIT(4)) dut1 (
    .axis_clk(clk), .axis_rst(rst), .bus(b1)
  );

  // BRAM model for dut0: read-first, one cycle latency, cleared in reset.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      b0.tap_Do <= '0;
    end else if (b0.tap_EN) begin
      if (b0.tap_WE != 4'h0) mem[b0.tap_A[11:2]] <= b0.tap_Di;
      b0.tap_Do <= mem[b0.tap_A[11:2]];
    end
  end
  assign b1.tap_Do = 32'hC0DE_0001;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        creq, cwe;
    logic [11:0] caddr;
    logic [31:0] cwd;
    logic        ereq;
    logic [11:0] eaddr;
    logic        lock;
    logic        cg, eg;
    logic [3:0]  we;
    logic [11:0] a;
    logic        blk, crv;
    logic [31:0] crd;
    logic        erv;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [10];

  // Directed-sequence and model variables.
  int ng, cyc_cfg, waited, gc, wt;
  logic [11:0] last_ea;
  logic resumed;
  int m_burst, m_wait;
  bit m_last_eng, m_crv, m_erv, elig, st, ecg, eeg, last_cg;
  logic [31:0] m_crd, m_erd;
  logic [31:0] shadow [16];
  logic [11:0] exp_a;

  task automatic drive0(input logic creq, input logic cwe, input logic [11:0] caddr,
                        input logic [31:0] cwd, input logic ereq, input logic [11:0] eaddr,
                        input logic lock);
    b0.cfg_req = creq; b0.cfg_we = cwe; b0.cfg_addr = caddr; b0.cfg_wdata = cwd;
    b0.eng_req = ereq; b0.eng_addr = eaddr; b0.eng_lock = lock;
  endtask

  initial begin
    tbl[0] = '{1'b1,1'b1,12'h008,32'h5,   1'b0,12'h000,1'b0, 1'b1,1'b0,4'hF,12'h008,1'b0,1'b0,32'h0,   1'b0,32'h0};
    tbl[1] = '{1'b1,1'b0,12'h008,32'h0,   1'b0,12'h000,1'b0, 1'b1,1'b0,4'h0,12'h008,1'b0,1'b0,32'h0,   1'b0,32'h0};
    tbl[2] = '{1'b0,1'b0,12'h000,32'h0,   1'b0,12'h000,1'b0, 1'b0,1'b0,4'h0,12'h000,1'b0,1'b1,32'h5,   1'b0,32'h0};
    tbl[3] = '{1'b1,1'b1,12'h010,32'hA5A5,1'b0,12'h000,1'b1, 1'b0,1'b0,4'h0,12'h000,1'b1,1'b0,32'h0,   1'b0,32'h0};
    tbl[4] = '{1'b1,1'b1,12'h010,32'hA5A5,1'b0,12'h000,1'b0, 1'b1,1'b0,4'hF,12'h010,1'b0,1'b0,32'h0,   1'b0,32'h0};
    tbl[5] = '{1'b0,1'b0,12'h000,32'h0,   1'b1,12'h010,1'b1, 1'b0,1'b1,4'h0,12'h010,1'b0,1'b0,32'h0,   1'b0,32'h0};
    tbl[6] = '{1'b1,1'b0,12'h010,32'h0,   1'b0,12'h000,1'b1, 1'b1,1'b0,4'h0,12'h010,1'b0,1'b0,32'h0,   1'b1,32'hA5A5};
    tbl[7] = '{1'b1,1'b0,12'h008,32'h0,   1'b1,12'h004,1'b0, 1'b0,1'b1,4'h0,12'h004,1'b0,1'b1,32'hA5A5,1'b0,32'h0};
    tbl[8] = '{1'b1,1'b0,12'h008,32'h0,   1'b0,12'h000,1'b0, 1'b1,1'b0,4'h0,12'h008,1'b0,1'b0,32'h0,   1'b1,32'h0};
    tbl[9] = '{1'b0,1'b0,12'h000,32'h0,   1'b0,12'h000,1'b0, 1'b0,1'b0,4'h0,12'h000,1'b0,1'b1,32'h5,   1'b0,32'h0};

    // Reset with requests pending: all outputs must be 0.
    rst = 1'b1;
    drive0(1'b1, 1'b1, 12'h044, 32'hFFFF, 1'b1, 12'h020, 1'b1);
    b1.cfg_req = 1'b0; b1.cfg_we = 1'b0; b1.cfg_addr = '0; b1.cfg_wdata = '0;
    b1.eng_req = 1'b0; b1.eng_addr = '0; b1.eng_lock = 1'b0;
    @(negedge clk);
    chk("rst_cfg_gnt", 64'(b0.cfg_gnt), 64'(0));
    chk("rst_eng_gnt", 64'(b0.eng_gnt), 64'(0));
    chk("rst_tap_en",  64'(b0.tap_EN),  64'(0));
    chk("rst_tap_a",   64'(b0.tap_A),   64'(0));
    chk("rst_blocked", 64'(b0.cfg_wr_blocked), 64'(0));
    chk("rst_rvalid",  64'({b0.cfg_rvalid, b0.eng_rvalid}), 64'(0));
    @(posedge clk); #1;
    drive0(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive0(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd, tbl[i].ereq, tbl[i].eaddr, tbl[i].lock);
      @(negedge clk);
      chk($sformatf("v%0d_cfg_gnt", i), 64'(b0.cfg_gnt), 64'(tbl[i].cg));
      chk($sformatf("v%0d_eng_gnt", i), 64'(b0.eng_gnt), 64'(tbl[i].eg));
      chk($sformatf("v%0d_tap_en", i),  64'(b0.tap_EN),  64'(tbl[i].cg | tbl[i].eg));
      chk($sformatf("v%0d_tap_we", i),  64'(b0.tap_WE),  64'(tbl[i].we));
      chk($sformatf("v%0d_tap_a", i),   64'(b0.tap_A),   64'(tbl[i].a));
      chk($sformatf("v%0d_tap_di", i),  64'(b0.tap_Di),  64'(tbl[i].cg ? tbl[i].cwd : 32'h0));
      chk($sformatf("v%0d_blocked", i), 64'(b0.cfg_wr_blocked), 64'(tbl[i].blk));
      chk($sformatf("v%0d_cfg_rvalid", i), 64'(b0.cfg_rvalid), 64'(tbl[i].crv));
      chk($sformatf("v%0d_cfg_rdata", i),  64'(b0.cfg_rdata),  64'(tbl[i].crd));
      chk($sformatf("v%0d_eng_rvalid", i), 64'(b0.eng_rvalid), 64'(tbl[i].erv));
      chk($sformatf("v%0d_eng_rdata", i),  64'(b0.eng_rdata),  64'(tbl[i].erd));
    end

    // Full tap pass with cfg read arriving in burst cycle 2.
    ng = 0; cyc_cfg = -1; waited = 0; last_ea = '0;
    for (int c = 0; c < 24 && cyc_cfg < 0; c++) begin
      @(posedge clk); #1;
      drive0(c >= 1, 1'b0, 12'h008, 32'h0, 1'b1, 12'(ng * TAP_STRIDE), 1'b0);
      @(negedge clk);
      if (b0.eng_gnt) begin ng++; last_ea = b0.tap_A; end
      if (b0.cfg_gnt) cyc_cfg = c;
      else if (b0.cfg_req) waited++;
    end
    chk("burst_eng_grants", 64'(ng), 64'(11));
    chk("burst_cfg_cycle",  64'(cyc_cfg), 64'(11));
    chk("burst_last_addr",  64'(last_ea), 64'(12'h028));
    chk("burst_cfg_wait",   64'(waited), 64'(10));
    @(posedge clk); #1;
    drive0(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b0);

    // Starvation on the long-burst instance.
    gc = -1; wt = 0; resumed = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      b1.eng_req = 1'b1; b1.eng_addr = 12'(c * 4);
      b1.cfg_req = (c >= 2) && (gc < 0); b1.cfg_addr = 12'h00C;
      @(negedge clk);
      if (gc >= 0 && c == gc + 1) begin
        resumed = b1.eng_gnt;
        break;
      end
      if (b1.cfg_gnt) begin
        gc = c;
        chk("starve_excl", 64'(b1.eng_gnt), 64'(0));
      end else if (b1.cfg_req) wt++;
    end
    chk("starve_wait",   64'(wt), 64'(4));
    chk("starve_gnt_at", 64'(gc), 64'(6));
    chk("starve_resume", 64'(resumed), 64'(1));
    @(posedge clk); #1;
    b1.eng_req = 1'b0; b1.cfg_req = 1'b0;

    // Reset one cycle after an eng grant.
    @(posedge clk); #1;
    drive0(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 12'h000, 1'b0);
    @(negedge clk);
    chk("rstb_first_gnt", 64'(b0.eng_gnt), 64'(1));
    @(posedge clk); #1;
    drive0(1'b1, 1'b0, 12'h008, 32'h0, 1'b1, 12'h004, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rstb_gnts",   64'({b0.cfg_gnt, b0.eng_gnt}), 64'(0));
    chk("rstb_tap",    64'({b0.tap_EN, b0.tap_WE, b0.tap_A}), 64'(0));
    chk("rstb_rvalid", 64'({b0.eng_rvalid, b0.cfg_rvalid}), 64'(0));
    chk("rstb_rdata",  64'(b0.eng_rdata), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstb_tie_eng", 64'(b0.eng_gnt), 64'(1));
    chk("rstb_tie_cfg", 64'(b0.cfg_gnt), 64'(0));
    chk("rstb_no_rv",   64'(b0.eng_rvalid), 64'(0));

    // Randomized traffic against the behavioural model.
    @(posedge clk); #1;
    drive0(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_burst = 0; m_wait = 0; m_last_eng = 1'b0; m_crv = 1'b0; m_erv = 1'b0;
    m_crd = '0; m_erd = '0; last_cg = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (!b0.cfg_req || last_cg) begin
        b0.cfg_req   = ($urandom_range(0, 3) != 0);
        b0.cfg_we    = 1'($urandom_range(0, 1));
        b0.cfg_addr  = 12'h100 + 12'(4 * $urandom_range(0, 15));
        b0.cfg_wdata = $urandom;
      end
      b0.eng_req  = ($urandom_range(0, 9) != 0);
      b0.eng_addr = 12'h100 + 12'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) b0.eng_lock = ~b0.eng_lock;
      @(negedge clk);

      // Arbitration rules: cfg wins when starved or alone, eng runs bursts of
      // up to 11, ties alternate against the last winner.
      elig = b0.cfg_req && !(b0.cfg_we && b0.eng_lock);
      st   = (m_wait >= 16);
      ecg  = 1'b0; eeg = 1'b0;
      if (m_burst == 0) begin
        if (elig && (st || !b0.eng_req)) ecg = 1'b1;
        else if (b0.eng_req && (!elig || !m_last_eng)) eeg = 1'b1;
        else if (elig) ecg = 1'b1;
      end else begin
        if (b0.eng_req && m_burst < 11 && !st) eeg = 1'b1;
        else if (elig) ecg = 1'b1;
      end
      exp_a = ecg ? b0.cfg_addr : (eeg ? b0.eng_addr : 12'h0);

      chk("rnd_cfg_gnt", 64'(b0.cfg_gnt), 64'(ecg));
      chk("rnd_eng_gnt", 64'(b0.eng_gnt), 64'(eeg));
      chk("rnd_tap_we",  64'(b0.tap_WE),  64'((ecg && b0.cfg_we) ? 4'hF : 4'h0));
      chk("rnd_tap_a",   64'(b0.tap_A),   64'(exp_a));
      chk("rnd_blocked", 64'(b0.cfg_wr_blocked), 64'(b0.cfg_req && b0.cfg_we && b0.eng_lock));
      chk("rnd_cfg_rvalid", 64'(b0.cfg_rvalid), 64'(m_crv));
      chk("rnd_cfg_rdata",  64'(b0.cfg_rdata),  64'(m_crv ? m_crd : 32'h0));
      chk("rnd_eng_rvalid", 64'(b0.eng_rvalid), 64'(m_erv));
      chk("rnd_eng_rdata",  64'(b0.eng_rdata),  64'(m_erv ? m_erd : 32'h0));

      m_crv = ecg && !b0.cfg_we;
      m_crd = shadow[b0.cfg_addr[5:2]];
      m_erv = eeg;
      m_erd = shadow[b0.eng_addr[5:2]];
      if (ecg && b0.cfg_we) shadow[b0.cfg_addr[5:2]] = b0.cfg_wdata;
      m_burst = eeg ? m_burst + 1 : 0;
      if (eeg) m_last_eng = 1'b1;
      if (ecg) m_last_eng = 1'b0;
      if (ecg) m_wait = 0;
      else if (elig && !st) m_wait++;
      last_cg = b0.cfg_gnt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/tap_ram_arbiter.md
Name: tap_ram_arbiter

Overview:
- Shares the single-port tap coefficient BRAM between two requesters: the AXI-Lite configuration path (cfg, read/write) and the FIR engine address/MAC sequencer (eng, read-only).
- Grants at most one access per cycle and routes read data back to the owner.
- Locks out coefficient writes while the engine is running, and bounds cfg starvation during engine tap bursts.
- Sits between the AXI-Lite slave logic, the FIR sequencer and the tap_* BRAM pins.

Parameters:
- pADDR_WIDTH, 12, BRAM byte-address width
- pDATA_WIDTH, 32, BRAM data width
- BURST_LEN, 11, maximum consecutive eng grants per burst (one pass over all taps)
- MAX_WAIT, 16, cycles an eligible cfg request may wait before it takes absolute priority

Ports:
- axis_clk  in  1  clock; all logic is on the rising edge
- axis_rst  in  1  asynchronous, active-high reset
- cfg_req  in  1  cfg access request; level, held until granted
- cfg_we  in  1  1 = write, 0 = read; stable while cfg_req is high
- cfg_addr  in  pADDR_WIDTH  cfg byte address
- cfg_wdata  in  pDATA_WIDTH  cfg write data
- cfg_gnt  out  1  cfg access issued to the BRAM this cycle
- cfg_rvalid  out  1  cfg read data valid
- cfg_rdata  out  pDATA_WIDTH  cfg read data
- cfg_wr_blocked  out  1  cfg write is pending and refused because eng_lock is high
- eng_req  in  1  engine read request; level
- eng_addr  in  pADDR_WIDTH  engine tap byte address
- eng_gnt  out  1  engine read issued this cycle
- eng_rvalid  out  1  engine read data valid
- eng_rdata  out  pDATA_WIDTH  engine read data
- eng_lock  in  1  engine running; coefficient writes are forbidden
- tap_EN  out  1  BRAM enable
- tap_WE  out  4  BRAM byte write enables
- tap_A  out  pADDR_WIDTH  BRAM address
- tap_Di  out  pDATA_WIDTH  BRAM write data
- tap_Do  in  pDATA_WIDTH  BRAM read data, valid one cycle after the enabled read

Behaviour:
- Reset (async, mid-operation included):
  - All outputs go to 0; state = ARB; burst_cnt = 0; wait_cnt = 0; rr_last = CFG, so eng wins the first tie.
  - Any in-flight rvalid is dropped.
- Eligibility:
  - cfg is eligible when cfg_req=1 and NOT (cfg_we=1 and eng_lock=1).
  - cfg_wr_blocked = cfg_req & cfg_we & eng_lock, combinational.
  - A blocked write stays pending until eng_lock falls; no data is lost.
- Grants are combinational from state, registers and requests. cfg_gnt and eng_gnt are never both 1.
- A requester samples gnt at the rising edge, then may change its request.
- BRAM drive:
  - tap_EN = cfg_gnt | eng_gnt.
  - tap_A and tap_Di come from the granted requester.
  - tap_WE = 4'hF only when cfg_gnt & cfg_we; otherwise 0. When idle, tap_A = 0 and tap_Di = 0.
- Read return:
  - The owner tag is registered. rvalid goes high exactly one cycle after a read grant, to the owner only.
  - The owner's rdata = tap_Do in the rvalid cycle; rdata = 0 otherwise.
  - Writes produce no rvalid.
- Starved: wait_cnt == MAX_WAIT.
  - wait_cnt increments, saturating, each cycle cfg is eligible but not granted.
  - wait_cnt clears on cfg_gnt.
  - It holds while cfg is ineligible.
- FSM, state ARB:
  - Starved or (cfg eligible & !eng_req): grant cfg, rr_last = CFG.
  - Else eng_req & !cfg eligible: grant eng.
  - Else both requesting: the side that is not rr_last wins.
  - Any eng grant: rr_last = ENG, burst_cnt = 1, next state ENG_BURST.
- FSM, state ENG_BURST:
  - eng_req & burst_cnt < BURST_LEN & !starved: grant eng, burst_cnt++.
  - Otherwise: grant cfg if eligible (rr_last = CFG), else grant nobody; next state ARB, burst_cnt = 0.
  - An exit caused by eng_req dropping costs no cycle if cfg is waiting.
- Burst capacity: BURST_LEN=11 allows one full pass over tap addresses 0x00..0x28 without interruption unless cfg is starved.
- Addresses are passed through unchecked; range checking belongs to the AXI-Lite decoder.
- Counter widths: burst_cnt is $clog2(BURST_LEN+1) bits; wait_cnt is $clog2(MAX_WAIT+1) bits.

Decomposition:
- Shared package fir_pkg holds:
  - state encodings ARB=1'b0 and ENG_BURST=1'b1;
  - owner encodings CFG=1'b0 and ENG=1'b1;
  - the tap count 11 and tap address stride 4.
- No sub-module. One FSM with its grant logic, plus a return-path register, fits in a single module.

Test Plan:
- cfg write alone, addr 0x08, data 0x0000_0005, eng_lock=0 -> same cycle: cfg_gnt=1, tap_EN=1, tap_WE=4'hF, tap_A=0x08; no cfg_rvalid follows.
- cfg read of 0x08 after that write, with the bench BRAM model -> cfg_gnt in cycle N; cfg_rvalid=1 and cfg_rdata=0x5 in N+1; eng_rvalid stays 0.
- eng reads 0x00..0x28 continuously while cfg_req read is asserted from burst cycle 2 -> eng receives 11 consecutive grants; cfg is granted on the 12th cycle; cfg never waits more than 16 cycles.
- Starvation: BURST_LEN=32, MAX_WAIT=4, eng_req held, cfg read pending -> cfg_gnt after exactly 4 waiting cycles, then eng resumes.
- eng_lock=1 with cfg write to 0x10 -> cfg_wr_blocked=1, no grant, tap_WE stays 0; lock falls -> grant in that same cycle, tap_WE=4'hF.
- axis_rst pulsed mid-burst, one cycle after an eng read grant -> all outputs 0 immediately, no eng_rvalid; after release, a simultaneous cfg and eng request grants eng first.
